// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ALU operand pipeline register with EX/MEM and MEM/WB forwarding
//
// Purpose:
//   Holds one decoded instruction between register-file read and the ALU.
//   Capture uses a valid/ready handshake, so the stage can stall and be flushed.
//   Operands are patched with in-flight results from later stages. The
//   forwarding is combinational, so results that arrive during a stall still
//   reach the ALU.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   flush             squash the held and incoming instruction on the next edge
//   in_*              decoded instruction fields with in_valid/in_ready handshake
//   exmem_*, memwb_*  write-back buses of the two younger-result stages
//   out_valid/ready   output handshake toward the ALU stage
//   alu_a, alu_b      forwarded ALU operands (b may be the immediate)
//   alu_control       registered ALU operation
//   rs2_fwd           forwarded rs2 value (store data), independent of alu_src
//   rd_addr           registered destination register
//   reg_write         registered write enable, gated by out_valid

module ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_alu_src,
  input  logic [2:0]            in_alu_control,
  input  logic                  in_reg_write,

  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_result,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [2:0]            alu_control,
  output logic [XLEN-1:0]       rs2_fwd,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  reg_write
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                state_q,     state_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q,  rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q,  rs2_addr_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [XLEN-1:0]       rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]       imm_q,       imm_d;
  logic                  alu_src_q,   alu_src_d;
  logic [2:0]            alu_ctrl_q,  alu_ctrl_d;
  logic                  reg_write_q, reg_write_d;

  logic                  capture;
  logic [XLEN-1:0]       src1;
  logic [XLEN-1:0]       src2;

  // Accept whenever the slot is empty or is being drained this same cycle.
  // Draining and refilling in one cycle gives back-to-back, bubble-free flow.
  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign capture   = in_valid && in_ready && !flush;

  always_comb begin
    state_d     = state_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    alu_ctrl_d  = alu_ctrl_q;
    reg_write_d = reg_write_q;

    if (flush) begin
      // The payload is left stale; out_valid = 0 already masks it.
      state_d = EMPTY;
    end else if (capture) begin
      state_d     = FULL;
      rs1_addr_d  = in_rs1_addr;
      rs2_addr_d  = in_rs2_addr;
      rd_addr_d   = in_rd_addr;
      rs1_data_d  = in_rs1_data;
      rs2_data_d  = in_rs2_data;
      imm_d       = in_imm;
      alu_src_d   = in_alu_src;
      alu_ctrl_d  = in_alu_control;
      reg_write_d = in_reg_write;
    end else if (out_valid && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= 3'b000;
      reg_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      alu_ctrl_q  <= alu_ctrl_d;
      reg_write_q <= reg_write_d;
    end
  end

  // EX/MEM holds the youngest result, so it wins over MEM/WB. x0 is hardwired
  // to zero and is never forwarded, even when a stage claims to write it.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [XLEN-1:0]       rf_data,
    input logic                  ex_we,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [XLEN-1:0]       ex_res,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]       wb_res
  );
    logic [XLEN-1:0] sel;
    sel = rf_data;
    if (rs != '0) begin
      if (ex_we && (ex_rd == rs)) begin
        sel = ex_res;
      end else if (wb_we && (wb_rd == rs)) begin
        sel = wb_res;
      end
    end
    return sel;
  endfunction

  always_comb begin
    src1 = fwd_sel(rs1_addr_q, rs1_data_q,
                   exmem_reg_write, exmem_rd, exmem_result,
                   memwb_reg_write, memwb_rd, memwb_result);
    src2 = fwd_sel(rs2_addr_q, rs2_data_q,
                   exmem_reg_write, exmem_rd, exmem_result,
                   memwb_reg_write, memwb_rd, memwb_result);
  end

  assign alu_a       = src1;
  assign alu_b       = alu_src_q ? imm_q : src2;
  assign rs2_fwd     = src2;
  assign alu_control = alu_ctrl_q;
  assign rd_addr     = rd_addr_q;
  assign reg_write   = reg_write_q && out_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - self-checking bench for ex_operand_stage

module tb_ex_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_alu_src;
  logic [2:0]  in_alu_control;
  logic        in_reg_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a, alu_b, rs2_fwd;
  logic [2:0]  alu_control;
  logic [4:0]  rd_addr;
  logic        reg_write;

  int n_pass;
  int n_total;

  // Reference model: the single instruction slot, if any.
  logic        m_valid;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic        m_src;
  logic [2:0]  m_ctl;
  logic        m_rw;

  ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_alu_control(in_alu_control), .in_reg_write(in_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .rs2_fwd(rs2_fwd), .rd_addr(rd_addr), .reg_write(reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Most recent writer of a register wins; x0 always reads as the file value.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return rf;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_src = 0; m_ctl = 0; m_rw = 0;
  endtask

  task automatic model_step();
    logic ready;
    ready = !m_valid || out_ready;
    if (!rst_n) model_reset();
    else if (flush) m_valid = 0;
    else if (in_valid && ready) begin
      m_valid = 1;
      m_rs1 = in_rs1_addr; m_rs2 = in_rs2_addr; m_rd = in_rd_addr;
      m_d1 = in_rs1_data; m_d2 = in_rs2_data; m_imm = in_imm;
      m_src = in_alu_src; m_ctl = in_alu_control; m_rw = in_reg_write;
    end else if (m_valid && out_ready) m_valid = 0;
  endtask

  task automatic cmp_model();
    logic [31:0] s2;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("reg_write", {31'd0, reg_write}, {31'd0, m_valid && m_rw});
    if (m_valid) begin
      s2 = newest(m_rs2, m_d2);
      chk("alu_a", alu_a, newest(m_rs1, m_d1));
      chk("alu_b", alu_b, m_src ? m_imm : s2);
      chk("rs2_fwd", rs2_fwd, s2);
      chk("alu_control", {29'd0, alu_control}, {29'd0, m_ctl});
      chk("rd_addr", {27'd0, rd_addr}, {27'd0, m_rd});
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic src, input logic [2:0] ctl, input logic rw);
    in_rs1_addr = rs1; in_rs2_addr = rs2; in_rd_addr = rd;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
    in_alu_src = src; in_alu_control = ctl; in_reg_write = rw;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  logic [31:0] held_a;
  logic [2:0]  ctl_pick[5];

  initial begin
    n_pass = 0; n_total = 0;
    ctl_pick[0] = 3'b000; ctl_pick[1] = 3'b001; ctl_pick[2] = 3'b010;
    ctl_pick[3] = 3'b011; ctl_pick[4] = 3'b101;
    model_reset();
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    no_fwd();

    // Reset state
    wait_neg();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_control", {29'd0, alu_control}, 32'd0);
    chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    edge_step();
    rst_n = 1;

    // Plain add capture, then hold
    set_instr(5'd1, 5'd2, 5'd9, 32'h12345678, 32'h87654321, 32'h0, 1'b0, 3'b000, 1'b1);
    in_valid = 1; out_ready = 0;
    wait_neg(); edge_step();
    in_valid = 0;
    wait_neg();
    chk("add_out_valid", {31'd0, out_valid}, 32'd1);
    chk("add_alu_a", alu_a, 32'h12345678);
    chk("add_alu_b", alu_b, 32'h87654321);
    chk("add_alu_control", {29'd0, alu_control}, 32'd0);
    edge_step();

    // Immediate operand, captured back-to-back on accept
    set_instr(5'd3, 5'd4, 5'd7, 32'h11111111, 32'h5, 32'hFFFFFFFE, 1'b1, 3'b001, 1'b1);
    in_valid = 1; out_ready = 1;
    wait_neg(); edge_step();
    in_valid = 0; out_ready = 0;
    wait_neg();
    chk("imm_alu_b", alu_b, 32'hFFFFFFFE);
    chk("imm_rs2_fwd", rs2_fwd, 32'h5);
    chk("imm_rd_addr", {27'd0, rd_addr}, 32'd7);
    chk("imm_reg_write", {31'd0, reg_write}, 32'd1);

    // Forwarding priority on held rs1=3, recomputed while stalled
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAAAAAAAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h55555555;
    #1;
    chk("fwd_exmem", alu_a, 32'hAAAAAAAA);
    exmem_reg_write = 0;
    #1;
    chk("fwd_memwb", alu_a, 32'h55555555);
    cmp_model();
    edge_step();
    no_fwd();

    // Register 0 is never forwarded
    set_instr(5'd0, 5'd6, 5'd8, 32'h0, 32'h66, 32'h0, 1'b0, 3'b010, 1'b0);
    in_valid = 1; out_ready = 1;
    wait_neg(); edge_step();
    in_valid = 0; out_ready = 0;
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hDEADBEEF;
    wait_neg();
    chk("x0_no_fwd", alu_a, 32'h0);
    edge_step();
    no_fwd();

    // Stall for 3 cycles with a pending instruction
    held_a = alu_a;
    set_instr(5'd2, 5'd1, 5'd5, 32'hCAFEF00D, 32'h0BADF00D, 32'h0, 1'b0, 3'b011, 1'b1);
    in_valid = 1; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      wait_neg();
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_alu_a", alu_a, held_a);
      chk("stall_alu_control", {29'd0, alu_control}, 32'b010);
      edge_step();
    end
    out_ready = 1;
    wait_neg(); edge_step();
    in_valid = 0; out_ready = 0;
    wait_neg();
    chk("nobubble_valid", {31'd0, out_valid}, 32'd1);
    chk("nobubble_alu_a", alu_a, 32'hCAFEF00D);
    chk("nobubble_alu_control", {29'd0, alu_control}, 32'b011);

    // Flush while full with a new instruction offered
    flush = 1; in_valid = 1;
    edge_step();
    flush = 0; in_valid = 0;
    wait_neg();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_reg_write", {31'd0, reg_write}, 32'd0);
    edge_step();

    // Async reset in the middle of a stall
    set_instr(5'd1, 5'd1, 5'd3, 32'h77777777, 32'h1, 32'h0, 1'b0, 3'b000, 1'b1);
    in_valid = 1; out_ready = 0;
    wait_neg(); edge_step();
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_reg_write", {31'd0, reg_write}, 32'd0);
    wait_neg(); edge_step();
    rst_n = 1;

    // Randomized traffic; small register range to exercise forwarding hits
    for (int i = 0; i < 400; i++) begin
      set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                ctl_pick[$urandom_range(0, 4)], 1'($urandom_range(0, 1)));
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 9) == 0);
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_rd = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_rd = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
      wait_neg();
      edge_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Pipeline register between decode/register-file read and the ALU. Captures decoded operands with a valid/ready handshake and supports stall and flush.
- Forwards in-flight results from the EX/MEM and MEM/WB stages so the ALU sees up-to-date `a`/`b` values.
- Drives the ALU's `a`, `b` and `alu_control` inputs directly.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  squash held and incoming instruction
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage can accept
- in_rs1_addr  in  REG_ADDR_W  source 1 register index
- in_rs2_addr  in  REG_ADDR_W  source 2 register index
- in_rd_addr  in  REG_ADDR_W  destination register
- in_rs1_data  in  XLEN  register-file read 1
- in_rs2_data  in  XLEN  register-file read 2
- in_imm  in  XLEN  sign-extended immediate
- in_alu_src  in  1  1 selects imm for operand b
- in_alu_control  in  3  ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
- in_reg_write  in  1  instruction writes rd
- exmem_reg_write  in  1  EX/MEM stage writes back
- exmem_rd  in  REG_ADDR_W  EX/MEM destination
- exmem_result  in  XLEN  EX/MEM result
- memwb_reg_write  in  1  MEM/WB stage writes back
- memwb_rd  in  REG_ADDR_W  MEM/WB destination
- memwb_result  in  XLEN  MEM/WB result
- out_valid  out  1  ALU operands valid
- out_ready  in  1  downstream accepts
- alu_a  out  XLEN  ALU operand a
- alu_b  out  XLEN  ALU operand b
- alu_control  out  3  registered ALU op
- rs2_fwd  out  XLEN  forwarded rs2 (store data)
- rd_addr  out  REG_ADDR_W  registered rd
- reg_write  out  1  registered write enable, gated by out_valid

Behaviour:
- Reset (async, rst_n=0): out_valid=0 and all payload registers 0. As a result alu_a=0, alu_b=0, alu_control=000, rd_addr=0 and reg_write=0.
- Handshake: in_ready = !out_valid | out_ready (combinational).
- Capture: on a rising edge with in_valid & in_ready & !flush, latch all in_* fields and set out_valid=1.
- Drain: out_valid & out_ready with no new capture clears out_valid next cycle.
- Stall: out_valid & !out_ready holds every payload register unchanged. in_ready=0 during a stall.
- Flush: has priority over capture and hold. The next edge forces out_valid=0 and ignores in_valid that cycle. Payload registers may be left unchanged.
- State: two states. EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on capture.
  - FULL→FULL on hold, or on simultaneous accept+capture (back-to-back, zero bubble).
  - FULL→EMPTY on accept without capture, or on flush.
- Forwarding is combinational from registered rs addresses and live exmem/memwb buses; it is recomputed every cycle, including during a stall.
  - src1 = exmem_result if exmem_reg_write & exmem_rd==rs1 & rs1!=0.
  - else src1 = memwb_result if memwb_reg_write & memwb_rd==rs1 & rs1!=0.
  - else src1 = registered rs1_data. src2 follows the same rules.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- alu_a = src1; alu_b = registered alu_src ? registered imm : src2; rs2_fwd = src2 regardless of alu_src.
- reg_write output = registered reg_write & out_valid.
- Latency: one cycle from capture to out_valid. Forwarded values affect outputs in the same cycle.
- Reset asserted mid-stall clears immediately and asynchronously; no outputs remain X.

Test Plan:
- Reset, then capture add: rs1_data=0x12345678, rs2_data=0x87654321, alu_src=0, control=000, no forwarding → next cycle out_valid=1, alu_a=0x12345678, alu_b=0x87654321, alu_control=000.
- alu_src=1, imm=0xFFFFFFFE, rs2_data=0x5 → alu_b=0xFFFFFFFE, rs2_fwd=0x5.
- Held rs1=3; exmem_rd=3, exmem_result=0xAAAAAAAA, memwb_rd=3, memwb_result=0x55555555, both reg_write=1 → alu_a=0xAAAAAAAA. Deassert exmem_reg_write → alu_a=0x55555555.
- rs1=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xDEADBEEF, rs1_data=0 → alu_a=0.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs unchanged. Then out_ready=1 with new instruction → new payload captured with no bubble cycle.
- flush=1 while FULL and in_valid=1 → out_valid=0 next cycle and reg_write=0. Drop rst_n mid-stall → out_valid=0 and alu_a=0 without a clock edge.
